serial_adder: RTL and testbench

- Bit-serial two-operand adder built around a single-bit adder cell (half-adder pair plus carry flop).
- Accepts two WIDTH-bit operands over a valid/ready handshake and processes one bit per clock, LSB first.
- Presents the sum, carry-out and signed-overflow over a valid/ready output handshake.
- Serves as the area-lean arithmetic stage that combinational adder cells feed into for multi-bit datapaths.

---
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial two-operand adder: one bit per clock, LSB first, through a single
// half-adder-pair cell with a carry flop, valid/ready on both sides.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] sum_sr;
  logic [WIDTH-1:0] sum_next;
  logic [CW-1:0]    cnt;
  logic             carry, c_msb;
  logic             h1, g1, s_bit, c_next;
  logic             last_bit, pre_msb_bit;

  // Half-adder pair: first cell adds the operand bits, second adds the carry.
  always_comb begin
    h1       = a_sr[0] ^ b_sr[0];
    g1       = a_sr[0] & b_sr[0];
    s_bit    = h1 ^ carry;
    c_next   = g1 | (h1 & carry);
    // Sum register is one bit short: the final bit lands straight in sum.
    sum_next = {s_bit, sum_sr};
    last_bit    = (cnt == CW'(WIDTH - 1));
    pre_msb_bit = (cnt == CW'(WIDTH - 2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      c_msb  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        ADD: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_next[WIDTH-1:1];
          carry  <= c_next;
          cnt    <= cnt + 1'b1;
          // Carry leaving bit WIDTH-2 is the carry into the MSB.
          if (pre_msb_bit) c_msb <= c_next;
          if (last_bit) begin
            sum  <= sum_next;
            cout <= c_next;
            ovf  <= c_msb ^ c_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: expected results queued at input
// handshake, popped and compared at output handshake.
module tb_serial_adder;
  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int   checks = 0;
  int   failures = 0;
  int   results = 0;
  int   cyc = 0;
  res_t sb[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    res_t r;
    logic [W:0] full;
    full   = {1'b0, x} + {1'b0, y};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_result", 32'd1, 32'd0);
      end else begin
        res_t e;
        e = sb.pop_front();
        check("sum", 32'(sum), 32'(e.sum));
        check("cout", 32'(cout), 32'(e.cout));
        check("ovf", 32'(ovf), 32'(e.ovf));
      end
      results++;
    end
  end

  // Called just after a posedge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    bit done = 0;
    a = x; b = y; in_valid = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(x, y));
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin n = i; break; end
    end
    if (n == 0) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n, r0, e1, e2;
    bit got;

    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero operands plus latency
    out_ready = 1'b1;
    send(8'h00, 8'h00);
    check("busy_in_add", 32'(busy), 32'd1);
    wait_out_valid(n);
    check("latency", 32'(n), 32'(W));
    check("in_ready_done", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("in_ready_back", 32'(in_ready), 32'd1);
    check("out_valid_cleared", 32'(out_valid), 32'd0);

    // Carry / overflow corners
    send(8'hFF, 8'h01);
    send(8'h7F, 8'h01);
    send(8'h80, 8'h80);
    send(8'hA5, 8'h3C);
    drain();

    // Backpressure
    out_ready = 1'b0;
    send(8'h3C, 8'h5A);
    wait_out_valid(n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(sum), 32'h96);
      check("bp_flags", {30'd0, cout, ovf}, 32'b01);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Inputs ignored during ADD
    r0 = results;
    send(8'h12, 8'h34);
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 in_valid = 1'b0;
    drain();
    repeat (6) @(posedge clk);
    #1 check("single_result", 32'(results - r0), 32'd1);

    // Asynchronous reset mid-ADD
    send(8'h55, 8'h0F);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'h01, 8'h02);
    drain();

    // Back-to-back with in_valid and out_ready held
    out_ready = 1'b1;
    a = 8'h10; b = 8'h20; in_valid = 1'b1;
    e1 = -1; e2 = -1;
    for (int i = 0; i < 60 && e2 < 0; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (e1 < 0) begin
          sb.push_back(model(8'h10, 8'h20));
          e1 = cyc + 1;
          got = 1;
        end else begin
          sb.push_back(model(8'hF0, 8'h20));
          e2 = cyc + 1;
        end
      end
      @(posedge clk); #1;
      if (e1 >= 0) begin a = 8'hF0; b = 8'h20; end
    end
    in_valid = 1'b0;
    check("b2b_spacing", 32'(e2 - e1), 32'(W + 2));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
